exec_pipe: RTL and testbench
============================

# exec_pipe

Parametrised, pipelined successor to the single-cycle execute unit. Accepts MIPS R-type and immediate ALU instructions over a valid/ready handshake, reads operands from an internal register file, computes in a registered ALU stage and writes back. Full forwarding means dependent back-to-back instructions never stall. A debug read port replaces the per-register output wires. It sits between instruction fetch/decode and the future memory stage.

## Interface
- `XLEN`, 32: datapath and register width; must be ≥ 8.
- `NREG`, 32: implemented registers, a power of two in 2..32. Indices ≥ NREG read zero; writes to them are discarded.
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: `instr` holds an instruction.
- `instr_ready` out 1: block can accept an instruction this cycle.
- `instr` in 32: MIPS encoding.
- `busA` out XLEN: stage-1 operand A, registered.
- `busB` out XLEN: stage-1 operand B or extended immediate, registered.
- `busW` out XLEN: stage-2 result, registered.
- `wb_valid` out 1: `busW`/`wb_addr` hold a write in progress.
- `wb_addr` out 5: destination of that write.
- `dbg_addr` in 5: debug read index.
- `dbg_data` out XLEN: combinational `reg[dbg_addr]`; 0 for index 0 or ≥ NREG.

## Operation
- Handshake: an instruction transfers on a rising edge where `instr_valid && instr_ready`. With no transfer, a bubble enters the pipeline.
- R-type (op 0): ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, SLL 0x00, SRL 0x02. Destination is rd. Shifts use rt and shamt; shamt ≥ XLEN gives 0.
- I-type: ADDI 0x08 (imm sign-extended), ANDI 0x0C and ORI 0x0D (imm zero-extended). Destination is rt.
- ADD/SUB/ADDI wrap modulo 2^XLEN with no overflow trap. SLT is signed and yields 1 or 0.
- Any other encoding is a NOP: it flows down the pipe with `wb_valid`=0.
- Register 0 always reads 0. A write to register 0 gives `wb_valid`=1 but is discarded.
- Operand forwarding priority: (1) combinational ALU result of the instruction currently in stage 1; (2) `busW` if `wb_valid`; (3) register file.

## Timing
- Accept on edge E0. `busA`/`busB` update at E0. `busW`, `wb_valid` and `wb_addr` update at E1. The register file writes at E2. `dbg_data` shows the new value after E2.
- Throughput is one instruction per cycle. Without MULT_EN, `instr_ready` is 1 whenever not in reset.
- Reset: `instr_ready`, `busA`, `busB`, `busW`, `wb_valid` and `wb_addr` go to 0 immediately. All registers clear to 0. In-flight instructions are dropped. `instr_ready` rises on the first edge after `rst` deasserts.
- A bubble clears the stage's valid flag and holds `busA`/`busB`/`busW` at their previous values.

## Configuration
- `EXEC_MULT_EN` defined: adds 2×XLEN HI/LO registers and an FSM with states IDLE and BUSY.
  - MULT (funct 0x18) performs an unsigned shift-add multiply, one multiplier bit per cycle, taking XLEN cycles.
  - On MULT acceptance, `instr_ready` drops in the following cycle and stays low for exactly XLEN cycles, then returns to 1 with HI/LO updated.
  - MFHI 0x10 / MFLO 0x12 write HI/LO to rd through the normal pipeline.
  - Reset in BUSY returns to IDLE and clears HI/LO.
- `EXEC_MULT_EN` undefined: no HI/LO registers and no FSM; MULT/MFHI/MFLO are NOPs.

## Test plan
- ADDI $1,$0,5 → ADDI $2,$0,7 → ADD $3,$1,$2, back-to-back with no stall → `busW`=12 at E1 of the ADD; `dbg_addr`=3 reads 12 after E2.
- ADDI $4,$0,0 → SUB $5,$4,$1 where $1=1 → `busW`=0xFFFFFFFF; SLT $6,$5,$1 → 1.
- ADDI $0,$0,9 → `wb_valid`=1, `wb_addr`=0; `dbg_addr`=0 still reads 0. Encoding 0xFC000000 → `wb_valid` stays 0.
- `instr_valid` toggling 1,0,1 with dependent ADDs → bubble between them, forwarding from `busW` still correct; ORI $7,$0,0xFFFF → 0x0000FFFF.
- `EXEC_MULT_EN`: $1=0x10000, MULT $1,$1 → `instr_ready` low for 32 cycles; then MFHI $8 → 1, MFLO $9 → 0.
- `rst` pulsed mid-MULT on cycle 10 → all outputs 0 immediately; `instr_ready`=1 one edge after release; MFLO returns 0.

Source files
------------

// File: rtl/exec_pipe.sv
// rtl/exec_pipe.sv - pipelined MIPS ALU execute unit with full forwarding and debug read port
// Optional HI/LO shift-add multiplier enabled by defining EXEC_MULT_EN.
module exec_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] busA,
  output logic [XLEN-1:0] busB,
  output logic [XLEN-1:0] busW,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_PASS = 4'd7;

  logic [XLEN-1:0] r_bus_a, r_bus_b, r_bus_w;
  logic            r_wb_valid, r_ready;
  logic [4:0]      r_wb_addr;
  logic            r_s1_valid, r_s1_wen;
  logic [3:0]      r_s1_op;
  logic [4:0]      r_s1_dst, r_s1_shamt;
  logic [XLEN-1:0] r_regs [NREG];

  logic [5:0]      w_op, w_funct;
  logic [4:0]      w_rs, w_rt, w_rd, w_shamt;
  logic [15:0]     w_imm;
  logic [3:0]      w_dec_op;
  logic            w_dec_wen, w_dec_use_imm;
  logic [4:0]      w_dec_dst;
  logic [1:0]      w_dec_a_sel;
  logic [XLEN-1:0] w_dec_imm, w_rs_val, w_rt_val, w_opa, w_opb, w_alu;
  logic            w_accept, w_ready_next;

  assign w_op    = instr[31:26];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_rd    = instr[15:11];
  assign w_shamt = instr[10:6];
  assign w_funct = instr[5:0];
  assign w_imm   = instr[15:0];
  assign w_accept = instr_valid && r_ready;

  // Indices 0 and >= NREG never hold data, so they are also excluded from forwarding.
  function automatic logic f_idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREG);
  endfunction

  function automatic logic [XLEN-1:0] f_fwd(input logic [4:0] idx);
    if (!f_idx_ok(idx))
      return '0;
    else if (r_s1_valid && r_s1_wen && r_s1_dst == idx)
      return w_alu;
    else if (r_wb_valid && r_wb_addr == idx)
      return r_bus_w;
    else
      return r_regs[idx[AW-1:0]];
  endfunction

`ifdef EXEC_MULT_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam int CW = $clog2(XLEN) + 1;
  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN:0]     w_sum;
  logic              w_dec_mult, w_last;
`endif

  always_comb begin
    w_dec_op      = ALU_ADD;
    w_dec_wen     = 1'b0;
    w_dec_dst     = w_rd;
    w_dec_use_imm = 1'b0;
    w_dec_imm     = '0;
    w_dec_a_sel   = 2'd0;
`ifdef EXEC_MULT_EN
    w_dec_mult    = 1'b0;
`endif
    case (w_op)
      6'h00: begin
        w_dec_wen = 1'b1;
        case (w_funct)
          6'h20: w_dec_op = ALU_ADD;
          6'h22: w_dec_op = ALU_SUB;
          6'h24: w_dec_op = ALU_AND;
          6'h25: w_dec_op = ALU_OR;
          6'h2A: w_dec_op = ALU_SLT;
          6'h00: w_dec_op = ALU_SLL;
          6'h02: w_dec_op = ALU_SRL;
`ifdef EXEC_MULT_EN
          6'h10: begin w_dec_op = ALU_PASS; w_dec_a_sel = 2'd1; end
          6'h12: begin w_dec_op = ALU_PASS; w_dec_a_sel = 2'd2; end
          6'h18: begin w_dec_wen = 1'b0; w_dec_mult = 1'b1; end
`endif
          default: w_dec_wen = 1'b0;
        endcase
      end
      6'h08: begin
        w_dec_wen = 1'b1; w_dec_dst = w_rt; w_dec_use_imm = 1'b1;
        w_dec_imm = XLEN'($signed(w_imm));
      end
      6'h0C, 6'h0D: begin
        w_dec_wen = 1'b1; w_dec_dst = w_rt; w_dec_use_imm = 1'b1;
        w_dec_op  = (w_op == 6'h0C) ? ALU_AND : ALU_OR;
        w_dec_imm = XLEN'(w_imm);
      end
      default: ;
    endcase
  end

  assign w_rs_val = f_fwd(w_rs);
  assign w_rt_val = f_fwd(w_rt);
  assign w_opb    = w_dec_use_imm ? w_dec_imm : w_rt_val;

  always_comb begin
    w_opa = w_rs_val;
`ifdef EXEC_MULT_EN
    if (w_dec_a_sel == 2'd1) w_opa = r_hi;
    else if (w_dec_a_sel == 2'd2) w_opa = r_lo;
`endif
  end

  always_comb begin
    w_alu = '0;
    case (r_s1_op)
      ALU_ADD:  w_alu = r_bus_a + r_bus_b;
      ALU_SUB:  w_alu = r_bus_a - r_bus_b;
      ALU_AND:  w_alu = r_bus_a & r_bus_b;
      ALU_OR:   w_alu = r_bus_a | r_bus_b;
      ALU_SLT:  w_alu = XLEN'($signed(r_bus_a) < $signed(r_bus_b));
      ALU_SLL:  w_alu = (int'(r_s1_shamt) >= XLEN) ? '0 : (r_bus_b << r_s1_shamt);
      ALU_SRL:  w_alu = (int'(r_s1_shamt) >= XLEN) ? '0 : (r_bus_b >> r_s1_shamt);
      ALU_PASS: w_alu = r_bus_a;
      default:  w_alu = '0;
    endcase
  end

`ifdef EXEC_MULT_EN
  // One multiplier bit per cycle: add multiplicand into the upper half, then shift right.
  assign w_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_last = (r_cnt == CW'(XLEN - 1));
  assign w_ready_next = (r_state == S_IDLE) ? !(w_accept && w_dec_mult) : w_last;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_dec_mult) begin
        r_state <= S_BUSY;
        r_cnt   <= '0;
        r_mcand <= w_rs_val;
        r_prod  <= {{XLEN{1'b0}}, w_rt_val};
      end
    end else begin
      r_prod <= {w_sum, r_prod[XLEN-1:1]};
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_state      <= S_IDLE;
        {r_hi, r_lo} <= {w_sum, r_prod[XLEN-1:1]};
      end
    end
  end
`else
  assign w_ready_next = 1'b1;
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_wen   <= 1'b0;
      r_s1_op    <= ALU_ADD;
      r_s1_dst   <= '0;
      r_s1_shamt <= '0;
      r_bus_a    <= '0;
      r_bus_b    <= '0;
      r_bus_w    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_ready    <= w_ready_next;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_bus_a    <= w_opa;
        r_bus_b    <= w_opb;
        r_s1_op    <= w_dec_op;
        r_s1_wen   <= w_dec_wen;
        r_s1_dst   <= w_dec_dst;
        r_s1_shamt <= w_shamt;
      end
      r_wb_valid <= r_s1_valid && r_s1_wen;
      if (r_s1_valid) begin
        r_bus_w   <= w_alu;
        r_wb_addr <= r_s1_dst;
      end
      if (r_wb_valid && f_idx_ok(r_wb_addr))
        r_regs[r_wb_addr[AW-1:0]] <= r_bus_w;
    end
  end

  assign instr_ready = r_ready;
  assign busA        = r_bus_a;
  assign busB        = r_bus_b;
  assign busW        = r_bus_w;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign dbg_data    = f_idx_ok(dbg_addr) ? r_regs[dbg_addr[AW-1:0]] : '0;

endmodule

// File: tb/tb_exec_pipe.sv
// tb/tb_exec_pipe.sv - scoreboard bench for exec_pipe (covers EXEC_MULT_EN when defined)
module tb_exec_pipe;

  logic        CLK = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] busA, busB, busW;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  exec_pipe #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .busA(busA), .busB(busB), .busW(busW), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  low_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rt_(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic send(input logic [31:0] ins, input bit exp, input logic [4:0] a,
                      input logic [31:0] d);
    @(negedge CLK);
    chk("instr_ready_at_issue", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    if (exp) exp_q.push_back({a, d});
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bubble(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_instr_ready"}, 32'(instr_ready), 32'd0);
    chk({tag, "_busA"}, busA, 32'd0);
    chk({tag, "_busB"}, busB, 32'd0);
    chk({tag, "_busW"}, busW, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
  endtask

  // Monitor: every write-back cycle must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (rst === 1'b0 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got addr %0d data 0x%08h expected no write", wb_addr, busW);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(mon_e.addr));
        chk("wb_data", busW, mon_e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 5'd0;
    repeat (2) @(negedge CLK);
    chk_zero_outputs("reset");
    rst = 1'b0;
    #1 chk("ready_before_first_edge", 32'(instr_ready), 32'd0);
    @(posedge CLK); #1 chk("ready_after_first_edge", 32'(instr_ready), 32'd1);

    // Dependent back-to-back adds.
    send(it_(6'h08, 5'd0, 5'd1, 16'd5), 1, 5'd1, 32'd5);
    send(it_(6'h08, 5'd0, 5'd2, 16'd7), 1, 5'd2, 32'd7);
    send(rt_(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1, 5'd3, 32'd12);
    drain();
    dbg_addr = 5'd3;
    #1 chk("dbg_reg3", dbg_data, 32'd12);

    // SUB wraps, SLT signed.
    send(it_(6'h08, 5'd0, 5'd1, 16'd1), 1, 5'd1, 32'd1);
    send(it_(6'h08, 5'd0, 5'd4, 16'd0), 1, 5'd4, 32'd0);
    send(rt_(5'd4, 5'd1, 5'd5, 5'd0, 6'h22), 1, 5'd5, 32'hFFFF_FFFF);
    send(rt_(5'd5, 5'd1, 5'd6, 5'd0, 6'h2A), 1, 5'd6, 32'd1);
    drain();

    // Register 0 write is visible on wb but discarded; unknown encoding is a NOP.
    send(it_(6'h08, 5'd0, 5'd0, 16'd9), 1, 5'd0, 32'd9);
    send(rt_(5'd0, 5'd0, 5'd11, 5'd0, 6'h20), 1, 5'd11, 32'd0);
    send(32'hFC00_0000, 0, 5'd0, 32'd0);
    drain();
    dbg_addr = 5'd0;
    #1 chk("dbg_reg0", dbg_data, 32'd0);

    // Bubble between dependent adds, then logic/shift mix.
    send(it_(6'h08, 5'd0, 5'd12, 16'd3), 1, 5'd12, 32'd3);
    bubble(1);
    send(rt_(5'd12, 5'd12, 5'd13, 5'd0, 6'h20), 1, 5'd13, 32'd6);
    send(rt_(5'd13, 5'd12, 5'd14, 5'd0, 6'h20), 1, 5'd14, 32'd9);
    send(it_(6'h0D, 5'd0, 5'd7, 16'hFFFF), 1, 5'd7, 32'h0000_FFFF);
    send(it_(6'h0C, 5'd7, 5'd15, 16'h00F0), 1, 5'd15, 32'h0000_00F0);
    send(it_(6'h08, 5'd0, 5'd16, 16'hFFFF), 1, 5'd16, 32'hFFFF_FFFF);
    send(rt_(5'd0, 5'd7, 5'd17, 5'd4, 6'h00), 1, 5'd17, 32'h000F_FFF0);
    send(rt_(5'd0, 5'd16, 5'd18, 5'd28, 6'h02), 1, 5'd18, 32'h0000_000F);
    send(rt_(5'd17, 5'd18, 5'd19, 5'd0, 6'h25), 1, 5'd19, 32'h000F_FFFF);
    send(rt_(5'd16, 5'd7, 5'd20, 5'd0, 6'h24), 1, 5'd20, 32'h0000_FFFF);
    send(rt_(5'd1, 5'd5, 5'd21, 5'd0, 6'h2A), 1, 5'd21, 32'd0);
    drain();
    dbg_addr = 5'd14;
    #1 chk("dbg_reg14", dbg_data, 32'd9);
    dbg_addr = 5'd7;
    #1 chk("dbg_reg7", dbg_data, 32'h0000_FFFF);

`ifdef EXEC_MULT_EN
    send(it_(6'h0D, 5'd0, 5'd1, 16'd1), 1, 5'd1, 32'd1);
    send(rt_(5'd0, 5'd1, 5'd1, 5'd16, 6'h00), 1, 5'd1, 32'h0001_0000);
    send(rt_(5'd1, 5'd1, 5'd0, 5'd0, 6'h18), 0, 5'd0, 32'd0);
    @(negedge CLK);
    instr_valid = 1'b0;
    low_cycles = 0;
    while (!instr_ready && low_cycles < 100) begin
      low_cycles++;
      @(negedge CLK);
    end
    chk("mult_busy_cycles", 32'(low_cycles), 32'd32);
    send(rt_(5'd0, 5'd0, 5'd8, 5'd0, 6'h10), 1, 5'd8, 32'd1);
    send(rt_(5'd0, 5'd0, 5'd9, 5'd0, 6'h12), 1, 5'd9, 32'd0);
    drain();

    // Reset in the middle of a multiply.
    send(rt_(5'd1, 5'd1, 5'd0, 5'd0, 6'h18), 0, 5'd0, 32'd0);
    @(negedge CLK);
    instr_valid = 1'b0;
    repeat (9) @(negedge CLK);
`else
    send(rt_(5'd1, 5'd1, 5'd0, 5'd0, 6'h18), 0, 5'd0, 32'd0);
    send(rt_(5'd0, 5'd0, 5'd8, 5'd0, 6'h10), 0, 5'd0, 32'd0);
    send(rt_(5'd0, 5'd0, 5'd9, 5'd0, 6'h12), 0, 5'd0, 32'd0);
    drain();
    chk("ready_no_mult", 32'(instr_ready), 32'd1);

    // Reset with an instruction in flight; it must be dropped.
    send(rt_(5'd1, 5'd1, 5'd22, 5'd0, 6'h20), 0, 5'd0, 32'd0);
`endif
    @(posedge CLK);
    #2 rst = 1'b1;
    instr_valid = 1'b0;
    dbg_addr = 5'd7;
    #1 chk_zero_outputs("async_reset");
    chk("reset_clears_reg7", dbg_data, 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    #1 chk("ready_low_after_release", 32'(instr_ready), 32'd0);
    @(posedge CLK); #1 chk("ready_high_one_edge_after", 32'(instr_ready), 32'd1);

`ifdef EXEC_MULT_EN
    send(rt_(5'd0, 5'd0, 5'd9, 5'd0, 6'h12), 1, 5'd9, 32'd0);
    send(rt_(5'd0, 5'd0, 5'd8, 5'd0, 6'h10), 1, 5'd8, 32'd0);
`endif
    send(it_(6'h08, 5'd0, 5'd23, 16'hFFFD), 1, 5'd23, 32'hFFFF_FFFD);
    send(rt_(5'd23, 5'd14, 5'd24, 5'd0, 6'h20), 1, 5'd24, 32'hFFFF_FFFD);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
